// File: rtl/sha256_block_feeder.sv
// Purpose: SHA-256 pre-processor. Packs a big-endian word stream into 512-bit blocks with FIPS 180-4 padding and length.
// Latency: a block is valid 1 cycle after its final word is accepted; a spilled tail block follows 2 cycles after the previous block is accepted.
// Backpressure: a valid block is held stable and word input is stalled until readyIn. Optional block counter: SHA256_FEEDER_BLOCK_COUNT_EN.
module sha256_block_feeder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wordIn,
  input  logic        wordValidIn,
  input  logic        wordLastIn,
  input  logic [2:0]  wordBytesIn,
  output logic        wordReadyOut,
  output logic [31:0] blockOut [0:15],
  output logic        validOut,
  output logic        firstBlockOut,
  output logic        lastBlockOut,
  input  logic        readyIn
`ifdef SHA256_FEEDER_BLOCK_COUNT_EN
  ,
  output logic [31:0] blockCountOut
`endif
);

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_EMIT    = 2'd1;
  localparam logic [1:0] ST_PADTAIL = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [60:0] cnt_q, cnt_d;
  logic [31:0] blk_q [0:15];
  logic [31:0] blk_d [0:15];
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        msg_start_q, msg_start_d;   // next emitted block opens a new message
  logic        tail_q, tail_d;             // length did not fit, a tail block follows
  logic        tail80_q, tail80_d;         // tail block also carries the 0x80 marker

  logic        word_acc;
  logic        blk_acc;
  logic [2:0]  n_bytes;
  logic [6:0]  used;
  logic [60:0] cnt_fin;
  logic [60:0] len_src;
  logic [63:0] bit_len;
  logic [31:0] pad_word;

  assign wordReadyOut  = (state_q == ST_FILL) && !rst;
  assign validOut      = (state_q == ST_EMIT);
  assign firstBlockOut = first_q;
  assign lastBlockOut  = last_q;
  assign word_acc      = wordValidIn && wordReadyOut;
  assign blk_acc       = validOut && readyIn;

  for (genvar g = 0; g < 16; g++) begin : g_out
    assign blockOut[g] = blk_q[g];
  end

  // Byte count of the final word saturates at a full word; used = bytes of this block holding data.
  assign n_bytes = (wordBytesIn > 3'd4) ? 3'd4 : wordBytesIn;
  assign used    = {1'b0, idx_q, 2'b00} + {4'b0, n_bytes};
  assign cnt_fin = cnt_q + {58'd0, n_bytes};
  // In PadTail the counter already holds the final count; in Fill the last word's bytes are added now.
  assign len_src = (state_q == ST_PADTAIL) ? cnt_q : cnt_fin;
  assign bit_len = {len_src, 3'b000};

  // Final word: keep the valid bytes, put 0x80 right after them, zero the rest.
  always_comb begin
    pad_word = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(n_bytes)) begin
        pad_word[31-8*b -: 8] = wordIn[31-8*b -: 8];
      end else if (b == int'(n_bytes)) begin
        pad_word[31-8*b -: 8] = 8'h80;
      end
    end
  end

  // Next-state logic for fill, emit and tail-building.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    last_d      = last_q;
    msg_start_d = msg_start_q;
    tail_d      = tail_q;
    tail80_d    = tail80_q;
    for (int k = 0; k < 16; k++) begin
      blk_d[k] = blk_q[k];
    end

    case (state_q)
      ST_FILL: begin
        if (word_acc) begin
          if (!wordLastIn) begin
            blk_d[idx_q] = wordIn;
            cnt_d        = cnt_q + 61'd4;
            if (idx_q == 4'd15) begin
              state_d     = ST_EMIT;
              idx_d       = 4'd0;
              first_d     = msg_start_q;
              last_d      = 1'b0;
              msg_start_d = 1'b0;
              tail_d      = 1'b0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            // Words after the final one are stale from the previous block; clear them.
            // A full final word pushes the 0x80 marker into the next word.
            for (int k = 0; k < 16; k++) begin
              if (k == int'(idx_q)) begin
                blk_d[k] = pad_word;
              end else if (k > int'(idx_q)) begin
                blk_d[k] = ((k == int'(idx_q) + 1) && (n_bytes == 3'd4)) ? 32'h8000_0000 : 32'd0;
              end
            end
            state_d = ST_EMIT;
            idx_d   = 4'd0;
            first_d = msg_start_q;
            if (used <= 7'd55) begin
              blk_d[14]   = bit_len[63:32];
              blk_d[15]   = bit_len[31:0];
              last_d      = 1'b1;
              msg_start_d = 1'b1;
              cnt_d       = 61'd0;
              tail_d      = 1'b0;
              tail80_d    = 1'b0;
            end else begin
              last_d      = 1'b0;
              msg_start_d = 1'b0;
              cnt_d       = cnt_fin;
              tail_d      = 1'b1;
              tail80_d    = (used == 7'd64);
            end
          end
        end
      end
      ST_EMIT: begin
        if (blk_acc) begin
          state_d = tail_q ? ST_PADTAIL : ST_FILL;
        end
      end
      ST_PADTAIL: begin
        for (int k = 0; k < 16; k++) begin
          blk_d[k] = 32'd0;
        end
        blk_d[0]    = tail80_q ? 32'h8000_0000 : 32'd0;
        blk_d[14]   = bit_len[63:32];
        blk_d[15]   = bit_len[31:0];
        first_d     = 1'b0;
        last_d      = 1'b1;
        msg_start_d = 1'b1;
        tail_d      = 1'b0;
        tail80_d    = 1'b0;
        cnt_d       = 61'd0;
        state_d     = ST_EMIT;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // State registers; reset discards any partial block, pending tail and byte count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      idx_q       <= 4'd0;
      cnt_q       <= 61'd0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      msg_start_q <= 1'b1;
      tail_q      <= 1'b0;
      tail80_q    <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        blk_q[k] <= 32'd0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      last_q      <= last_d;
      msg_start_q <= msg_start_d;
      tail_q      <= tail_d;
      tail80_q    <= tail80_d;
      for (int k = 0; k < 16; k++) begin
        blk_q[k] <= blk_d[k];
      end
    end
  end

`ifdef SHA256_FEEDER_BLOCK_COUNT_EN
  logic [31:0] bcnt_q;

  // Count every block handed to the hasher, tail blocks included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q <= 32'd0;
    end else if (blk_acc) begin
      bcnt_q <= bcnt_q + 32'd1;
    end
  end

  assign blockCountOut = bcnt_q;
`endif

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Bench for sha256_block_feeder: random messages against a byte-level FIPS 180-4 padding model,
// plus directed padding boundaries, backpressure, tail bubble, throughput and mid-message reset.
module tb_sha256_block_feeder;

  localparam int MAXW = 500;

  typedef struct {
    logic [15:0][31:0] w;
    logic              first;
    logic              last;
  } blk_t;

  logic        clk;
  logic        rst;
  logic [31:0] wordIn;
  logic        wordValidIn;
  logic        wordLastIn;
  logic [2:0]  wordBytesIn;
  logic        wordReadyOut;
  logic [31:0] blockOut [0:15];
  logic        validOut;
  logic        firstBlockOut;
  logic        lastBlockOut;
  logic        readyIn;
`ifdef SHA256_FEEDER_BLOCK_COUNT_EN
  logic [31:0] blockCountOut;
`endif

  sha256_block_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .wordIn       (wordIn),
    .wordValidIn  (wordValidIn),
    .wordLastIn   (wordLastIn),
    .wordBytesIn  (wordBytesIn),
    .wordReadyOut (wordReadyOut),
    .blockOut     (blockOut),
    .validOut     (validOut),
    .firstBlockOut(firstBlockOut),
    .lastBlockOut (lastBlockOut),
    .readyIn      (readyIn)
`ifdef SHA256_FEEDER_BLOCK_COUNT_EN
    ,
    .blockCountOut(blockCountOut)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [7:0]  msg [$];
  blk_t        exp_q [$];
  blk_t        got_q [$];
  int          xfer_t [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: message bytes + 0x80 + zeros to 56 mod 64 + 64-bit big-endian bit length.
  task automatic build_expected();
    logic [7:0]  p [$];
    logic [63:0] bits;
    blk_t        e;
    int          nb;
    p = msg;
    bits = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 16; k++) begin
        e.w[k] = {p[64*b+4*k], p[64*b+4*k+1], p[64*b+4*k+2], p[64*b+4*k+3]};
      end
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic cmp_block(input blk_t e, input string pre);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_w%0d", pre, k), 64'(blockOut[k]), 64'(e.w[k]));
    end
    chk({pre, "_first"}, 64'(firstBlockOut), 64'(e.first));
    chk({pre, "_last"}, 64'(lastBlockOut), 64'(e.last));
  endtask

  task automatic drive_words(input int gap_max, input bit allow_extra);
    int          L, nw, rlast, nb, guard, total;
    bit          extra, is_last;
    logic [31:0] word;
    L = msg.size();
    if (L == 0) begin
      nw = 1; rlast = 0;
    end else begin
      nw = (L + 3) / 4; rlast = L - 4 * (nw - 1);
    end
    extra = allow_extra && (rlast == 4) && ($urandom_range(0, 3) == 0);
    total = nw + (extra ? 1 : 0);
    @(negedge clk);
    for (int w = 0; w < total; w++) begin
      is_last = (w == total - 1);
      nb = (w < nw - 1) ? 4 : ((w == nw - 1) ? rlast : 0);
      word = $urandom;
      for (int b = 0; b < nb; b++) word[31-8*b -: 8] = msg[4*w+b];
      repeat ($urandom_range(0, gap_max)) begin
        wordValidIn = 1'b0;
        @(negedge clk);
      end
      wordIn      = word;
      wordValidIn = 1'b1;
      wordLastIn  = is_last;
      if (!is_last)    wordBytesIn = 3'($urandom_range(0, 7));
      else if (nb == 4) wordBytesIn = 3'($urandom_range(4, 7));
      else              wordBytesIn = 3'(nb);
      guard = 0;
      while (!wordReadyOut && guard < MAXW) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= MAXW) begin
        chk("word_ready_timeout", 64'(wordReadyOut), 64'd1);
        break;
      end
      @(negedge clk);
    end
    wordValidIn = 1'b0;
    wordLastIn  = 1'b0;
  endtask

  task automatic recv_blocks(input int rmode);
    int   guard, bi;
    blk_t e, g;
    bi = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      guard = 0;
      forever begin
        @(negedge clk);
        readyIn = (rmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        if (validOut && readyIn) break;
        guard++;
        if (guard > MAXW) break;
      end
      if (guard > MAXW) begin
        chk("block_timeout", 64'(validOut), 64'd1);
        readyIn = 1'b0;
        return;
      end
      xfer_t.push_back(cyc);
      cmp_block(e, $sformatf("blk%0d", bi));
      chk("blk_word_ready_low", 64'(wordReadyOut), 64'd0);
      for (int k = 0; k < 16; k++) g.w[k] = blockOut[k];
      g.first = firstBlockOut;
      g.last  = lastBlockOut;
      got_q.push_back(g);
      bi++;
    end
    @(negedge clk);
    readyIn = 1'b0;
  endtask

  task automatic run_msg(input int rmode, input int gap_max, input bit allow_extra);
    build_expected();
    got_q.delete();
    xfer_t.delete();
    fork
      drive_words(gap_max, allow_extra);
      recv_blocks(rmode);
    join
  endtask

  task automatic set_abc();
    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
  endtask

  task automatic set_rand(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  initial begin
    int   lens [10];
    logic [31:0] mid_or;
    blk_t e;
    lens = '{55, 56, 57, 60, 63, 64, 65, 119, 120, 128};
    rst = 1'b1; wordIn = '0; wordValidIn = 1'b0; wordLastIn = 1'b0;
    wordBytesIn = '0; readyIn = 1'b0;

    repeat (3) @(negedge clk);
    mid_or = '0;
    for (int k = 0; k < 16; k++) mid_or = mid_or | blockOut[k];
    chk("rst_word_ready", 64'(wordReadyOut), 64'd0);
    chk("rst_valid", 64'(validOut), 64'd0);
    chk("rst_flags", 64'({firstBlockOut, lastBlockOut}), 64'd0);
    chk("rst_block_zero", 64'(mid_or), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(wordReadyOut), 64'd1);

    // "abc"
    set_abc();
    run_msg(0, 0, 1'b0);
    if (got_q.size() == 1) begin
      mid_or = '0;
      for (int k = 1; k < 15; k++) mid_or = mid_or | got_q[0].w[k];
      chk("abc_w0", 64'(got_q[0].w[0]), 64'h61626380);
      chk("abc_mid_zero", 64'(mid_or), 64'd0);
      chk("abc_w15", 64'(got_q[0].w[15]), 64'h18);
      chk("abc_first_last", 64'({got_q[0].first, got_q[0].last}), 64'd3);
    end else chk("abc_nblocks", 64'(got_q.size()), 64'd1);

    // empty message
    msg.delete();
    run_msg(1, 1, 1'b0);
    if (got_q.size() == 1) begin
      chk("empty_w0", 64'(got_q[0].w[0]), 64'h80000000);
      chk("empty_w15", 64'(got_q[0].w[15]), 64'd0);
      chk("empty_first_last", 64'({got_q[0].first, got_q[0].last}), 64'd3);
    end else chk("empty_nblocks", 64'(got_q.size()), 64'd1);

    // 56 bytes: length spills into a tail block, which follows after one bubble cycle
    set_rand(56);
    run_msg(0, 0, 1'b1);
    if (got_q.size() == 2) begin
      chk("b56_blk1_w14", 64'(got_q[0].w[14]), 64'h80000000);
      chk("b56_blk1_w15", 64'(got_q[0].w[15]), 64'd0);
      chk("b56_blk1_flags", 64'({got_q[0].first, got_q[0].last}), 64'd2);
      chk("b56_blk2_w0", 64'(got_q[1].w[0]), 64'd0);
      chk("b56_blk2_w15", 64'(got_q[1].w[15]), 64'h1C0);
      chk("b56_blk2_flags", 64'({got_q[1].first, got_q[1].last}), 64'd1);
      chk("b56_tail_gap", 64'(xfer_t[1] - xfer_t[0]), 64'd2);
    end else chk("b56_nblocks", 64'(got_q.size()), 64'd2);

    // 64 bytes
    set_rand(64);
    run_msg(0, 0, 1'b0);
    if (got_q.size() == 2) begin
      chk("b64_blk1_w15", 64'(got_q[0].w[15]), 64'({msg[60], msg[61], msg[62], msg[63]}));
      chk("b64_blk2_w0", 64'(got_q[1].w[0]), 64'h80000000);
      chk("b64_blk2_w15", 64'(got_q[1].w[15]), 64'h200);
      chk("b64_blk2_last", 64'(got_q[1].last), 64'd1);
    end else chk("b64_nblocks", 64'(got_q.size()), 64'd2);

    // throughput: two full blocks back to back, 16 word cycles + 1 emit cycle apart
    set_rand(135);
    run_msg(0, 0, 1'b0);
    if (xfer_t.size() == 3) chk("thruput_gap", 64'(xfer_t[1] - xfer_t[0]), 64'd17);
    else chk("thruput_nblocks", 64'(xfer_t.size()), 64'd3);

    // backpressure: block held for 10 cycles
    set_abc();
    build_expected();
    e = exp_q[0];
    @(negedge clk);
    wordIn = 32'h616263A5; wordValidIn = 1'b1; wordLastIn = 1'b1; wordBytesIn = 3'd3; readyIn = 1'b0;
    chk("bp_word_ready", 64'(wordReadyOut), 64'd1);
    @(negedge clk);
    wordValidIn = 1'b0; wordLastIn = 1'b0;
    chk("bp_latency_valid", 64'(validOut), 64'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(validOut), 64'd1);
      chk("bp_hold_w0", 64'(blockOut[0]), 64'(e.w[0]));
      chk("bp_hold_w15", 64'(blockOut[15]), 64'(e.w[15]));
      chk("bp_hold_flags", 64'({firstBlockOut, lastBlockOut}), 64'({e.first, e.last}));
      chk("bp_hold_word_ready", 64'(wordReadyOut), 64'd0);
    end
    readyIn = 1'b1;
    cmp_block(e, "bp");
    @(negedge clk);
    readyIn = 1'b0;
    chk("bp_after_valid", 64'(validOut), 64'd0);
    chk("bp_after_word_ready", 64'(wordReadyOut), 64'd1);

    // random messages, boundary lengths first
    for (int i = 0; i < 40; i++) begin
      set_rand((i < 10) ? lens[i] : $urandom_range(0, 150));
      run_msg($urandom_range(0, 1), $urandom_range(0, 2), 1'b1);
    end

    // reset mid-message, then "abc" must come out clean
    @(negedge clk);
    for (int w = 0; w < 5; w++) begin
      wordIn = $urandom; wordValidIn = 1'b1; wordLastIn = 1'b0;
      @(negedge clk);
    end
    wordValidIn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_word_ready", 64'(wordReadyOut), 64'd0);
    chk("mid_rst_valid", 64'(validOut), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    set_abc();
    run_msg(0, 0, 1'b0);
    if (got_q.size() == 1) begin
      chk("rst_abc_w0", 64'(got_q[0].w[0]), 64'h61626380);
      chk("rst_abc_w15", 64'(got_q[0].w[15]), 64'h18);
      chk("rst_abc_first", 64'(got_q[0].first), 64'd1);
    end else chk("rst_abc_nblocks", 64'(got_q.size()), 64'd1);
`ifdef SHA256_FEEDER_BLOCK_COUNT_EN
    chk("rst_abc_block_count", 64'(blockCountOut), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/sha256_block_feeder.md
# sha256_block_feeder

Producer side of the SHA-256 block interface: accepts a message as a big-endian 32-bit word stream, applies FIPS 180-4 padding and 64-bit length, and emits 512-bit blocks. Each block carries first/last flags and is held until the hasher signals it is ready. Sits between the miner's header/message source and the SHA-256 hasher. Its outputs connect directly to the hasher's block inputs.

## Interface
Parameters: none.

Ports:
- clk  input  1  sole clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- wordIn  input  32  message word; first message byte in [31:24]
- wordValidIn  input  1  wordIn valid
- wordLastIn  input  1  final word of message (qualified by wordValidIn)
- wordBytesIn  input  3  valid bytes in last word, 0..4, left-justified; ignored unless wordLastIn; values 5..7 treated as 4
- wordReadyOut  output  1  feeder can accept a word this cycle
- blockOut  output  32×[0:15]  padded block; word 0 first
- validOut  output  1  blockOut valid
- firstBlockOut  output  1  block is first of its message
- lastBlockOut  output  1  block is last of its message (contains length)
- readyIn  input  1  hasher accepts block (wire to hasher readyForBlockOut)

## Operation
- Word handshake: word accepted on edge where wordValidIn && wordReadyOut.
- Block handshake: block transferred on edge where validOut && readyIn.
- States:
  - Fill: accept words into word index i (0..15).
  - Emit: hold block until it is accepted.
  - PadTail: build the extra padding block.
- Transitions:
  - Fill→Emit on the 16th accepted word, or on any last word.
  - Emit→Fill on acceptance, unless a tail block is pending; then Emit→PadTail.
  - PadTail→Emit after one cycle, with tail block loaded.
- Byte counter (61 bit) adds 4 per non-last word and wordBytesIn on the last word. Bit length = count<<3, placed in words 14 (high) and 15 (low). Counter wraps mod 2^61.
- Padding on last word at index i with n bytes: u = 4i+n bytes used.
  - Byte u gets 0x80; all following bytes are 0x00; bytes beyond n in the last word are overwritten.
  - If u ≤ 55, length goes in this block and lastBlockOut=1.
  - Otherwise this block is non-last and a tail block follows: zeros plus length. If u==64, the tail word 0 is 0x80000000.
- Full block without last: emitted non-last; Fill resumes at i=0.
- firstBlockOut=1 on the first block after reset or after the previous message's last block. A single-block message asserts firstBlockOut and lastBlockOut together.
- Empty message: single word with wordLastIn=1, wordBytesIn=0.

## Timing
- Reset values:
  - wordReadyOut=0 while rst is high.
  - validOut=0, firstBlockOut=0, lastBlockOut=0, blockOut all zero.
  - Byte counter=0, i=0, state Fill.
- wordReadyOut = (state==Fill) && !rst. It is 1 on the first cycle after reset release.
- validOut rises the cycle after the accepting word edge: 1-cycle latency from the final word.
- While validOut=1, blockOut, firstBlockOut and lastBlockOut are stable; wordReadyOut=0.
- After acceptance:
  - wordReadyOut=1 on the next cycle, or
  - tail block validOut=1 two cycles after acceptance (PadTail bubble).
- readyIn held high: throughput is 16 word cycles + 1 emit cycle per block.
- readyIn is ignored while validOut=0.
- rst mid-message: partial block, pending tail and byte counter are discarded. The next accepted word starts a new message with firstBlockOut=1.

## Configuration
- SHA256_FEEDER_BLOCK_COUNT_EN defined:
  - Adds output blockCountOut [31:0], reset 0.
  - Increments on every accepted block, tail blocks included; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- "abc": one word 0x61626300, last, bytes=3 → one block.
  - word0=0x61626380, words1–14=0, word15=0x00000018.
  - first=last=1.
- Empty message: 0x00000000, last, bytes=0 → word0=0x80000000, all else 0, word15=0, first=last=1.
- 56 bytes (14 words, last bytes=4) → two blocks.
  - Block 1: word14=0x80000000, word15=0, first=1, last=0.
  - Block 2: words0–14=0, word15=0x000001C0, first=0, last=1.
- 64 bytes (16 words) → block 1 is the raw data with first=1, last=0. Block 2: word0=0x80000000, word15=0x00000200, last=1.
- Backpressure: readyIn=0 for 10 cycles with validOut=1 → blockOut and flags stable, wordReadyOut=0. The block transfers on the cycle readyIn=1.
- rst asserted after 5 words, then "abc" sent → block identical to the first scenario, first=1. With SHA256_FEEDER_BLOCK_COUNT_EN, blockCountOut=1.
